// File: rtl/pong_fb_pkg.sv
// rtl/pong_fb_pkg.sv - shared sizes and FSM state type for the Pong framebuffer arbiter
package pong_fb_pkg;
    localparam int X_MAX_DEF  = 320;
    localparam int Y_MAX_DEF  = 240;
    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 17;
    localparam int X_W        = 10;
    localparam int Y_W        = 9;

    typedef enum logic [1:0] {
        IDLE,
        RD_ADDR,
        RD_CAP,
        WR
    } fb_state_t;
endpackage

// File: rtl/pong_scan_counter.sv
// rtl/pong_scan_counter.sv - raster x/y wrap counters with line and frame end strobes
module pong_scan_counter
    import pong_fb_pkg::*;
#(
    parameter int X_MAX = X_MAX_DEF,
    parameter int Y_MAX = Y_MAX_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           pix_ce,
    output logic [X_W-1:0] scan_x,
    output logic [Y_W-1:0] scan_y,
    output logic           line_end,
    output logic           frame_end
);
    localparam logic [X_W-1:0] X_LAST = X_W'(X_MAX - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(Y_MAX - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_x    <= '0;
            scan_y    <= '0;
            line_end  <= 1'b0;
            frame_end <= 1'b0;
        end else begin
            line_end  <= 1'b0;
            frame_end <= 1'b0;
            if (pix_ce) begin
                if (scan_x == X_LAST) begin
                    scan_x   <= '0;
                    line_end <= 1'b1;
                    if (scan_y == Y_LAST) begin
                        scan_y    <= '0;
                        frame_end <= 1'b1;
                    end else begin
                        scan_y <= scan_y + 1'b1;
                    end
                end else begin
                    scan_x <= scan_x + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/fb_scan_arbiter.sv
// rtl/fb_scan_arbiter.sv - scan-out read / game write arbiter for the single-port framebuffer RAM
module fb_scan_arbiter
    import pong_fb_pkg::*;
#(
    parameter int X_MAX  = X_MAX_DEF,
    parameter int Y_MAX  = Y_MAX_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_ce,
    output logic [X_W-1:0]    scan_x,
    output logic [Y_W-1:0]    scan_y,
    output logic              line_end,
    output logic              frame_end,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    input  logic              wr_req,
    input  logic [X_W-1:0]    wr_x,
    input  logic [Y_W-1:0]    wr_y,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              wr_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              overrun
);
    fb_state_t         state;
    logic              rd_pending;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] cur_addr;
    logic              wr_oob;
    logic              wr_oob_q;

    function automatic logic [ADDR_W-1:0] pix_addr(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        return ADDR_W'(y) * ADDR_W'(X_MAX) + ADDR_W'(x);
    endfunction

    pong_scan_counter #(
        .X_MAX(X_MAX),
        .Y_MAX(Y_MAX)
    ) u_scan (
        .clk      (clk),
        .reset    (reset),
        .pix_ce   (pix_ce),
        .scan_x   (scan_x),
        .scan_y   (scan_y),
        .line_end (line_end),
        .frame_end(frame_end)
    );

    assign cur_addr = pix_addr(scan_x, scan_y);
    assign wr_oob   = (wr_x >= X_W'(X_MAX)) || (wr_y >= Y_W'(Y_MAX));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rd_pending <= 1'b0;
            rd_addr    <= '0;
            wr_oob_q   <= 1'b0;
            pix_data   <= '0;
            pix_valid  <= 1'b0;
            wr_ack     <= 1'b0;
            wr_err     <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            overrun    <= 1'b0;
        end else begin
            pix_valid <= 1'b0;
            wr_ack    <= 1'b0;
            wr_err    <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;

            if (pix_ce) begin
                rd_addr    <= cur_addr;
                rd_pending <= 1'b1;
                if (rd_pending) overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (rd_pending) begin
                        // A pix_ce landing now supersedes the older pending address,
                        // so only the newest position is ever read out.
                        state      <= RD_ADDR;
                        mem_en     <= 1'b1;
                        mem_addr   <= pix_ce ? cur_addr : rd_addr;
                        rd_pending <= 1'b0;
                    end else if (wr_req) begin
                        state    <= WR;
                        wr_oob_q <= wr_oob;
                        if (!wr_oob) begin
                            mem_en    <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_addr  <= pix_addr(wr_x, wr_y);
                            mem_wdata <= wr_data;
                        end
                    end
                end
                RD_ADDR: state <= RD_CAP;
                RD_CAP: begin
                    pix_data  <= mem_rdata;
                    pix_valid <= 1'b1;
                    state     <= IDLE;
                end
                WR: begin
                    wr_ack <= 1'b1;
                    wr_err <= wr_oob_q;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fb_scan_arbiter.sv
// tb/tb_fb_scan_arbiter.sv - self-checking bench for fb_scan_arbiter with a framebuffer RAM model
module tb_fb_scan_arbiter;
    localparam int XM = 320;
    localparam int YM = 240;
    localparam int NPIX = XM * YM;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pix_ce = 1'b0;
    logic [9:0]  scan_x;
    logic [8:0]  scan_y;
    logic        line_end, frame_end;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        wr_req = 1'b0;
    logic [9:0]  wr_x = '0;
    logic [8:0]  wr_y = '0;
    logic [7:0]  wr_data = '0;
    logic        wr_ack, wr_err;
    logic        mem_en, mem_we;
    logic [16:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic        overrun;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;

    // Reference model: scan position and framebuffer contents as plain numbers.
    int        mx = 0, my = 0;
    logic [7:0] shadow [int];
    logic [7:0] ram_mem [int];
    logic       last_le, last_fe;
    logic [7:0] last_data;

    fb_scan_arbiter dut (
        .clk(clk), .reset(reset), .pix_ce(pix_ce),
        .scan_x(scan_x), .scan_y(scan_y), .line_end(line_end), .frame_end(frame_end),
        .pix_data(pix_data), .pix_valid(pix_valid),
        .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .wr_ack(wr_ack), .wr_err(wr_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .overrun(overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input int a);
        return 8'(a) ^ 8'h5A;
    endfunction

    // Synchronous single-port RAM, preloaded with init_val.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram_mem[int'(mem_addr)] = mem_wdata;
            else mem_rdata <= ram_mem.exists(int'(mem_addr)) ? ram_mem[int'(mem_addr)] : init_val(int'(mem_addr));
        end
    end

    function automatic logic [7:0] ref_at(input int a);
        return shadow.exists(a) ? shadow[a] : init_val(a);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic advance_model();
        mx++;
        if (mx == XM) begin
            mx = 0;
            my = (my == YM - 1) ? 0 : my + 1;
        end
    endtask

    task automatic do_reset();
        #3 reset = 1'b1;
        #1;
        check("rst_pix_valid", pix_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_scan", {scan_x, 7'd0, scan_y}, 0);
        check("rst_mem_en", {mem_en, mem_we, wr_ack, wr_err}, 0);
        tick();
        reset = 1'b0;
        mx = 0;
        my = 0;
    endtask

    task automatic do_read(input string tag);
        int         a;
        logic [7:0] exp;
        bit         seen;
        a = my * XM + mx;
        exp = ref_at(a);
        pix_ce = 1'b1;
        tick();
        pix_ce = 1'b0;
        last_le = line_end;
        last_fe = frame_end;
        advance_model();
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            if (pix_valid) begin
                seen = 1;
                last_data = pix_data;
                check(tag, pix_data, exp);
            end
        end
        check({tag, "_valid"}, seen, 1);
    endtask

    task automatic do_write(input int x, input int y, input logic [7:0] d);
        bit oob, acked, err;
        int we_seen;
        logic [16:0] we_addr;
        oob = (x >= XM) || (y >= YM);
        wr_x = 10'(x);
        wr_y = 9'(y);
        wr_data = d;
        wr_req = 1'b1;
        acked = 0; err = 0; we_seen = 0; we_addr = '0;
        for (int i = 0; i < 10 && !acked; i++) begin
            tick();
            if (mem_we) begin
                we_seen++;
                we_addr = mem_addr;
                check("wr_wdata", mem_wdata, d);
            end
            if (wr_ack) begin
                acked = 1;
                err = wr_err;
            end
        end
        wr_req = 1'b0;
        check("wr_ack_seen", acked, 1);
        check("wr_err", err, oob);
        check("wr_we_count", we_seen, oob ? 0 : 1);
        if (!oob) begin
            check("wr_addr", we_addr, y * XM + x);
            shadow[y * XM + x] = d;
        end
    endtask

    initial begin
        int le_cnt, fe_cnt, bad;
        int a, sx;
        bit seen;

        // Reset state and first read timing.
        do_reset();
        pix_ce = 1'b1;
        tick();
        pix_ce = 1'b0;
        advance_model();
        check("first_scan_x", scan_x, 1);
        check("first_mem_en_k", mem_en, 0);
        tick();
        check("first_mem_en_k1", {mem_en, mem_we}, 2'b10);
        check("first_mem_addr", mem_addr, 0);
        tick();
        check("first_valid_k2", pix_valid, 0);
        tick();
        check("first_valid_k3", pix_valid, 1);
        check("first_pix_data", pix_data, 8'h5A);
        tick();

        // One full line: line_end only on the last pix_ce.
        do_reset();
        le_cnt = 0; bad = 0;
        for (int n = 1; n <= XM; n++) begin
            do_read("line_rd");
            if (last_le) le_cnt++;
            if (last_le !== (n == XM)) bad++;
            if (last_fe) bad++;
        end
        check("line_end_position", bad, 0);
        check("line_end_count", le_cnt, 1);
        check("line_scan", {22'd0, scan_x}, 0);
        check("line_scan_y", scan_y, 1);

        // Directed write then scan forward to read it back.
        do_write(5, 2, 8'h33);
        while (!(mx == 5 && my == 2)) do_read("walk_rd");
        do_read("rd_5_2");
        check("rd_5_2_value", last_data, 8'h33);

        // Out-of-bounds writes.
        do_write(320, 0, 8'h11);
        do_write(0, 240, 8'h22);
        do_write(1023, 511, 8'h44);

        // Write and pix_ce together: write granted first, read two cycles later.
        a = my * XM + mx;
        wr_x = 10'(mx); wr_y = 9'(my); wr_data = 8'hC3;
        wr_req = 1'b1;
        pix_ce = 1'b1;
        tick();
        pix_ce = 1'b0;
        advance_model();
        check("sim_we", {mem_en, mem_we}, 2'b11);
        check("sim_wr_addr", mem_addr, a);
        tick();
        check("sim_ack", wr_ack, 1);
        wr_req = 1'b0;
        shadow[a] = 8'hC3;
        tick();
        check("sim_rd_en", {mem_en, mem_we}, 2'b10);
        check("sim_rd_addr", mem_addr, a);
        seen = 0;
        for (int i = 0; i < 6 && !seen; i++) begin
            tick();
            if (pix_valid) begin
                seen = 1;
                check("sim_rd_data", pix_data, 8'hC3);
            end
        end
        check("sim_rd_valid", seen, 1);
        check("sim_overrun", overrun, 0);

        // Randomized mix of reads and writes, many landing just ahead of the scan.
        for (int it = 0; it < 200; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 3) == 0) begin
                    do_write($urandom_range(0, 340), $urandom_range(0, 250), 8'($urandom));
                end else begin
                    a = my * XM + mx + $urandom_range(0, 4);
                    if (a < NPIX) do_write(a % XM, a / XM, 8'($urandom));
                end
            end else begin
                do_read("rand_rd");
            end
        end
        check("rand_overrun", overrun, 0);

        // Back-to-back pix_ce: overrun, one pix_valid for the second address.
        sx = int'(scan_x);
        pix_ce = 1'b1;
        tick();
        advance_model();
        a = my * XM + mx;
        tick();
        pix_ce = 1'b0;
        advance_model();
        le_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (pix_valid) begin
                le_cnt++;
                check("ovr_data", pix_data, ref_at(a));
            end
            tick();
        end
        check("ovr_valid_count", le_cnt, 1);
        check("ovr_overrun", overrun, 1);
        check("ovr_scan_x", scan_x, (sx + 2) % XM);
        do_reset();
        check("ovr_cleared", overrun, 0);

        // Full frame with pix_ce every cycle.
        le_cnt = 0; fe_cnt = 0; bad = 0;
        pix_ce = 1'b1;
        for (int n = 1; n <= NPIX; n++) begin
            tick();
            if (line_end) le_cnt++;
            if (frame_end) fe_cnt++;
            if (line_end !== ((n % XM) == 0)) bad++;
            if (frame_end !== (n == NPIX)) bad++;
        end
        pix_ce = 1'b0;
        check("frame_strobe_pos", bad, 0);
        check("frame_line_count", le_cnt, YM);
        check("frame_end_count", fe_cnt, 1);
        check("frame_scan", {scan_x, scan_y}, 0);
        repeat (6) tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/fb_scan_arbiter.md
Name: fb_scan_arbiter

Overview:
Sequences the Pong framebuffer. It owns the raster X/Y scan counters and shares the single-port synchronous framebuffer RAM between two requesters:
- display scan-out reads, which have priority;
- game-logic pixel writes from the paddle/ball renderer.

It also produces the line-end and frame-end strobes the rest of the video path keys off.

Parameters:
X_MAX, 320, pixels per line; x counts 0..X_MAX-1
Y_MAX, 240, lines per frame; y counts 0..Y_MAX-1
DATA_W, 8, pixel data width
ADDR_W, 17, RAM address width; must satisfy 2^ADDR_W >= X_MAX*Y_MAX

Ports:
clk  in  1  system clock
reset  in  1  reset, asynchronous, active-high
pix_ce  in  1  one-cycle pixel strobe from video timing; requests a read of the current scan position
scan_x  out  10  current scan column
scan_y  out  9  current scan row
line_end  out  1  one-cycle pulse when x wraps
frame_end  out  1  one-cycle pulse when y wraps (coincides with line_end)
pix_data  out  DATA_W  read pixel
pix_valid  out  1  one-cycle pulse; pix_data is valid
wr_req  in  1  write request; held until wr_ack
wr_x  in  10  write column
wr_y  in  9  write row
wr_data  in  DATA_W  write pixel
wr_ack  out  1  one-cycle grant/complete pulse
wr_err  out  1  one-cycle pulse alongside wr_ack when the write is out of bounds
mem_en  out  1  RAM enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, valid one cycle after the read address edge
overrun  out  1  sticky: pix_ce arrived while a read was still pending

Behaviour:
- Reset (async assert): all outputs are 0 and state is IDLE. overrun is cleared only by reset.
- Address computation: mem_addr = y*X_MAX + x, computed at ADDR_W width.
- Scan counters, on each pix_ce:
  - Latch the read address from the current (scan_x, scan_y) and set rd_pending.
  - Then advance x. If x == X_MAX-1: x <= 0, pulse line_end, and y increments.
  - If y == Y_MAX-1 at the same time: y <= 0 and pulse frame_end.
  - Counters are registered, so new values appear the cycle after pix_ce.
- FSM states: IDLE, RD_ADDR, RD_CAP, WR.
  - IDLE and rd_pending: go to RD_ADDR. Drive mem_en=1, mem_we=0, mem_addr=latched address; clear rd_pending.
  - IDLE, no rd_pending, wr_req: go to WR.
    - In bounds: drive mem_en=1, mem_we=1, address from wr_x/wr_y, mem_wdata=wr_data.
    - Out of bounds (wr_x >= X_MAX or wr_y >= Y_MAX): mem_en=0.
  - RD_ADDR: go to RD_CAP. RD_CAP: register mem_rdata into pix_data, pulse pix_valid, return to IDLE.
  - WR: pulse wr_ack (plus wr_err if out of bounds), return to IDLE.
- Timing:
  - Read with the FSM idle: pix_ce sampled at edge k, mem_addr at edge k+1, pix_valid high after edge k+3.
  - Write: wr_ack one cycle after the grant edge.
- Arbitration: a pending read always beats wr_req. A write already in WR completes first, delaying the read by at most 1 cycle. wr_req is never starved as long as pix_ce spacing is >= 4 cycles.
- Simultaneous pix_ce and grant in IDLE: rd_pending is seen next cycle. The write proceeds this cycle.
- Overrun: pix_ce while rd_pending=1 sets overrun. The newer address replaces the old one, only one pix_valid is produced, and the counters still advance.
- wr_req dropped before wr_ack: illegal. Behaviour in that case is undefined.
- mem_we and mem_en are 0 in every state except the enabling cycle described above.
- Reset mid-transaction: the transaction is aborted. No pix_valid or wr_ack is produced.

Decomposition:
- Package pong_fb_pkg: X_MAX, Y_MAX, DATA_W, ADDR_W defaults, the coordinate widths (10 and 9), and the FSM state typedef (IDLE, RD_ADDR, RD_CAP, WR).
- Sub-module pong_scan_counter: x/y wrap counters with line_end/frame_end. Parameterised by X_MAX/Y_MAX, same clock and reset.

Test Plan:
- Reset then one pix_ce, RAM preloaded addr0=0x5A -> mem_addr=0 at edge k+1, pix_valid with pix_data=0x5A after edge k+3, scan_x=1.
- 320 pix_ce spaced 4 cycles -> line_end only on the 320th, scan_x=0, scan_y=1; after 76800 pix_ce -> frame_end with line_end, scan_x=0, scan_y=0.
- wr_req (x=5, y=2, data=0x33) with no reads -> mem_we=1, mem_addr=645, wr_ack next cycle; a subsequent read of (5,2) returns 0x33.
- wr_req and pix_ce asserted the same cycle in IDLE -> write granted first, read mem_addr driven 2 cycles later, both complete, overrun=0.
- wr_req with x=320, y=0 -> no mem_we, wr_ack and wr_err pulse together.
- pix_ce on two consecutive cycles -> overrun=1 (sticky), one pix_valid for the second address, scan_x advanced by 2; reset clears overrun.
